// File: rtl/im_loader.sv
// im_loader: frames a byte stream (A5, N, 4*N LE bytes [, xor checksum]) into IM word writes.
// Optional checksum byte and CSUM state are built when LOADER_CHECKSUM_EN is defined.
`default_nettype none

module im_loader #(
    parameter logic [31:0] ADDR_BASE = 32'd0,
    parameter int          MAX_WORDS = 64
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [7:0]  byte_i,
    input  logic        byte_valid_i,
    output logic        byte_ready_o,
    output logic        we_o,
    output logic [31:0] waddr_o,
    output logic [31:0] wdata_o,
    output logic        core_reset_o,
    output logic        done_o,
    output logic        err_o
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LEN   = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
`ifdef LOADER_CHECKSUM_EN
    localparam logic [2:0] S_CSUM  = 3'd4;
`endif
    localparam logic [2:0] S_DONE  = 3'd5;
    localparam logic [2:0] S_ERR   = 3'd6;

    localparam logic [8:0] MAX_LEN   = 9'(MAX_WORDS);
    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    logic [2:0]  state;
    logic [2:0]  state_next;
    logic        accept;
    logic [7:0]  n_words;
    logic [7:0]  word_idx;
    logic [1:0]  byte_cnt;
    logic [31:0] word_buf;
    logic [31:0] waddr_q;
    logic [31:0] wdata_q;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  csum;
`endif

    assign accept = byte_valid_i && (state != S_WRITE);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (accept && byte_i == SYNC_BYTE) state_next = S_LEN;
            end
            S_LEN: begin
                if (accept) begin
                    if (byte_i == 8'd0 || {1'b0, byte_i} > MAX_LEN) state_next = S_ERR;
                    else                                           state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (accept && byte_cnt == 2'd3) state_next = S_WRITE;
            end
            S_WRITE: begin
                if (word_idx + 8'd1 == n_words) begin
`ifdef LOADER_CHECKSUM_EN
                    state_next = S_CSUM;
`else
                    state_next = S_DONE;
`endif
                end else begin
                    state_next = S_DATA;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (accept) state_next = (byte_i == csum) ? S_DONE : S_ERR;
            end
`endif
            default: state_next = S_IDLE;
        endcase
    end

    // Status outputs are pure functions of the state so they move on the entering edge.
    always_comb begin
        byte_ready_o = (state != S_WRITE);
        we_o         = (state == S_WRITE);
        done_o       = (state == S_DONE);
        err_o        = (state == S_ERR);
        core_reset_o = (state != S_IDLE) && (state != S_DONE);
    end

    assign waddr_o = waddr_q;
    assign wdata_o = wdata_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            n_words  <= 8'd0;
            word_idx <= 8'd0;
            byte_cnt <= 2'd0;
            word_buf <= 32'd0;
            waddr_q  <= ADDR_BASE;
            wdata_q  <= 32'd0;
`ifdef LOADER_CHECKSUM_EN
            csum     <= 8'd0;
`endif
        end else begin
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (accept && byte_i == SYNC_BYTE) begin
                        word_idx <= 8'd0;
                        byte_cnt <= 2'd0;
`ifdef LOADER_CHECKSUM_EN
                        csum     <= 8'd0;
`endif
                    end
                end
                S_LEN: begin
                    if (accept) begin
                        n_words <= byte_i;
`ifdef LOADER_CHECKSUM_EN
                        csum    <= csum ^ byte_i;
`endif
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        word_buf[{byte_cnt, 3'b000} +: 8] <= byte_i;
                        byte_cnt <= byte_cnt + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                        csum     <= csum ^ byte_i;
`endif
                        // Capture address and data on the completing byte so they are valid during WRITE.
                        if (byte_cnt == 2'd3) begin
                            waddr_q <= ADDR_BASE + {22'd0, word_idx, 2'b00};
                            wdata_q <= {byte_i, word_buf[23:0]};
                        end
                    end
                end
                S_WRITE: begin
                    word_idx <= word_idx + 8'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_im_loader.sv
// Scoreboard bench for im_loader: expected writes queued at stimulus time, checked by a monitor.
`default_nettype none

module tb_im_loader;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b1;
    logic [7:0]  byte_i = 8'd0;
    logic        byte_valid_i = 1'b0;
    logic        byte_ready_o;
    logic        we_o;
    logic [31:0] waddr_o;
    logic [31:0] wdata_o;
    logic        core_reset_o;
    logic        done_o;
    logic        err_o;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] exp_q[$];
    logic [31:0] words[0:7];
    logic        prev_we = 1'b0;

    im_loader #(.ADDR_BASE(32'd0), .MAX_WORDS(64)) dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .byte_i       (byte_i),
        .byte_valid_i (byte_valid_i),
        .byte_ready_o (byte_ready_o),
        .we_o         (we_o),
        .waddr_o      (waddr_o),
        .wdata_o      (wdata_o),
        .core_reset_o (core_reset_o),
        .done_o       (done_o),
        .err_o        (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every write must match the head of the scoreboard.
    always @(negedge clk_i) begin
        if (reset_i) begin
            prev_we = 1'b0;
        end else begin
            chk("ready_vs_we", {31'd0, byte_ready_o}, {31'd0, ~we_o});
            if (we_o) begin
                chk("we_width", {31'd0, prev_we}, 32'd0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", waddr_o, 32'hFFFF_FFFF);
                end else begin
                    logic [63:0] e;
                    e = exp_q.pop_front();
                    chk("waddr", waddr_o, e[63:32]);
                    chk("wdata", wdata_o, e[31:0]);
                end
            end
            prev_we = we_o;
        end
    end

    // Called with time just after a posedge; returns just after the accepting posedge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        logic rdy;
        int   tries;
        byte_valid_i = 1'b0;
        repeat (gap) @(posedge clk_i);
        #1;
        byte_i       = b;
        byte_valid_i = 1'b1;
        tries = 0;
        rdy   = 1'b0;
        while (!rdy && tries < 20) begin
            @(negedge clk_i);
            rdy = byte_ready_o;
            @(posedge clk_i);
            tries++;
        end
        if (!rdy) chk("accept_timeout", 32'd0, 32'd1);
        #1;
        byte_valid_i = 1'b0;
    endtask

    task automatic send_frame(input int n, input int maxgap, input logic bad_csum);
        logic [7:0] cs;
        logic [31:0] w;
        cs = 8'(n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({32'(i) * 32'd4, words[i]});
            w = words[i];
            cs = cs ^ w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
        end
        send_byte(8'hA5, $urandom_range(maxgap));
        chk("core_reset_on_sync", {31'd0, core_reset_o}, 32'd1);
        chk("done_clr_on_sync", {31'd0, done_o}, 32'd0);
        send_byte(8'(n), $urandom_range(maxgap));
        for (int i = 0; i < n; i++) begin
            w = words[i];
            for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], $urandom_range(maxgap));
        end
`ifdef LOADER_CHECKSUM_EN
        send_byte(bad_csum ? ~cs : cs, $urandom_range(maxgap));
`else
        if (bad_csum) chk("csum_test_requires_checksum", 32'd0, 32'd1);
`endif
    endtask

    task automatic check_status(input int waitc, input logic d, input logic e, input logic cr, input string tag);
        repeat (waitc) @(posedge clk_i);
        @(negedge clk_i);
        chk({tag, "_done"}, {31'd0, done_o}, {31'd0, d});
        chk({tag, "_err"}, {31'd0, err_o}, {31'd0, e});
        chk({tag, "_core_reset"}, {31'd0, core_reset_o}, {31'd0, cr});
        chk({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        words[0] = 32'h0000_0013;
        words[1] = 32'h0010_0093;
        words[2] = 32'hDEAD_BEEF;
        words[3] = 32'hA5A5_00FF;
        for (int i = 4; i < 8; i++) words[i] = 32'h0;

        #3;
        chk("rst_ready", {31'd0, byte_ready_o}, 32'd1);
        chk("rst_we", {31'd0, we_o}, 32'd0);
        chk("rst_waddr", waddr_o, 32'd0);
        chk("rst_wdata", wdata_o, 32'd0);
        chk("rst_core_reset", {31'd0, core_reset_o}, 32'd0);
        chk("rst_done_err", {30'd0, done_o, err_o}, 32'd0);
        @(posedge clk_i);
        #1 reset_i = 1'b0;
        @(posedge clk_i);
        #1;

        // Good 2-word load.
        send_frame(2, 0, 1'b0);
        check_status(1, 1'b1, 1'b0, 1'b0, "good");

`ifdef LOADER_CHECKSUM_EN
        send_frame(2, 0, 1'b1);
        check_status(1, 1'b0, 1'b1, 1'b1, "badcs");
        send_frame(2, 0, 1'b0);
        check_status(1, 1'b1, 1'b0, 1'b0, "recover");
`endif

        // Length errors.
        send_byte(8'hA5, 0);
        send_byte(8'h00, 0);
        check_status(0, 1'b0, 1'b1, 1'b1, "len0");
        send_byte(8'hA5, 0);
        send_byte(8'h41, 0);
        check_status(0, 1'b0, 1'b1, 1'b1, "len65");

        // Garbage before sync, and recovery from ERR.
        send_byte(8'h00, 0);
        send_byte(8'hFF, 1);
        send_byte(8'h5A, 0);
        check_status(0, 1'b0, 1'b1, 1'b1, "garbage");
        send_frame(2, 0, 1'b0);
        check_status(1, 1'b1, 1'b0, 1'b0, "after_garbage");

        // 3-word load with random valid gaps.
        send_frame(3, 7, 1'b0);
        check_status(1, 1'b1, 1'b0, 1'b0, "gaps");

        // Reset after the 2nd data byte of word 1: only word 0 may be written.
        exp_q.push_back({32'd0, words[0]});
        send_byte(8'hA5, 0);
        send_byte(8'h02, 0);
        for (int k = 0; k < 4; k++) send_byte(words[0][8*k +: 8], 0);
        send_byte(words[1][7:0], 0);
        send_byte(words[1][15:8], 0);
        reset_i = 1'b1;
        #2;
        chk("midrst_we", {31'd0, we_o}, 32'd0);
        chk("midrst_waddr", waddr_o, 32'd0);
        chk("midrst_wdata", wdata_o, 32'd0);
        chk("midrst_status", {29'd0, core_reset_o, done_o, err_o}, 32'd0);
        chk("midrst_queue_empty", 32'(exp_q.size()), 32'd0);
        @(posedge clk_i);
        #1 reset_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        words[0] = 32'h1234_5678;
        words[1] = 32'h9ABC_DEF0;
        send_frame(2, 2, 1'b0);
        check_status(1, 1'b1, 1'b0, 1'b0, "after_reset");

        repeat (3) @(posedge clk_i);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
